// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: carries execute results and MEM/WB controls into MEM, with stall, flush and a squash counter.
// Optional macro EX_MEM_FLAGS_EN adds the ex_nzcv/mem_nzcv condition-flag path.
module ex_mem_reg #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_branch,
    input  logic              ex_uncond_branch,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_write_data,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic [REG_W-1:0]  ex_rd,
`ifdef EX_MEM_FLAGS_EN
    input  logic [3:0]        ex_nzcv,
    output logic [3:0]        mem_nzcv,
`endif
    output logic              mem_valid,
    output logic              mem_reg_write,
    output logic              mem_mem_to_reg,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_branch,
    output logic              mem_uncond_branch,
    output logic              mem_zero,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [DATA_W-1:0] mem_branch_target,
    output logic [REG_W-1:0]  mem_rd,
    output logic [CNT_W-1:0]  squash_count
);

    localparam logic [REG_W-1:0] XZR = REG_W'(31);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    logic ld_reg_write;
    logic ld_mem_read;
    logic ld_mem_write;
    logic ld_branch;
    logic ld_uncond_branch;

    // Side-effecting controls are dropped for empty slots; writes to XZR are discarded.
    always_comb begin
        ld_reg_write     = ex_valid & ex_reg_write & (ex_rd != XZR);
        ld_mem_read      = ex_valid & ex_mem_read;
        ld_mem_write     = ex_valid & ex_mem_write;
        ld_branch        = ex_valid & ex_branch;
        ld_uncond_branch = ex_valid & ex_uncond_branch;
    end

    // EX -> MEM stage boundary
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_valid         <= 1'b0;
            mem_reg_write     <= 1'b0;
            mem_mem_to_reg    <= 1'b0;
            mem_mem_read      <= 1'b0;
            mem_mem_write     <= 1'b0;
            mem_branch        <= 1'b0;
            mem_uncond_branch <= 1'b0;
            mem_zero          <= 1'b0;
            mem_alu_result    <= '0;
            mem_write_data    <= '0;
            mem_branch_target <= '0;
            mem_rd            <= '0;
`ifdef EX_MEM_FLAGS_EN
            mem_nzcv          <= '0;
`endif
            squash_count      <= '0;
        end else if (flush_i) begin
            mem_valid         <= 1'b0;
            mem_reg_write     <= 1'b0;
            mem_mem_to_reg    <= 1'b0;
            mem_mem_read      <= 1'b0;
            mem_mem_write     <= 1'b0;
            mem_branch        <= 1'b0;
            mem_uncond_branch <= 1'b0;
            mem_zero          <= 1'b0;
            mem_alu_result    <= '0;
            mem_write_data    <= '0;
            mem_branch_target <= '0;
            mem_rd            <= '0;
`ifdef EX_MEM_FLAGS_EN
            mem_nzcv          <= '0;
`endif
            if (ex_valid) begin
                squash_count <= sat_inc(squash_count);
            end
        end else if (!stall_i) begin
            mem_valid         <= ex_valid;
            mem_reg_write     <= ld_reg_write;
            mem_mem_to_reg    <= ex_mem_to_reg;
            mem_mem_read      <= ld_mem_read;
            mem_mem_write     <= ld_mem_write;
            mem_branch        <= ld_branch;
            mem_uncond_branch <= ld_uncond_branch;
            mem_zero          <= ex_zero;
            mem_alu_result    <= ex_alu_result;
            mem_write_data    <= ex_write_data;
            mem_branch_target <= ex_branch_target;
            mem_rd            <= ex_rd;
`ifdef EX_MEM_FLAGS_EN
            mem_nzcv          <= ex_nzcv;
`endif
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus randomized traffic against a rule-level model.
// Built with a 2-bit squash counter so saturation is reachable; honours EX_MEM_FLAGS_EN.
module tb_ex_mem_reg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef EX_MEM_FLAGS_EN
    localparam int VW = 8 + 3 * DATA_W + REG_W + 4;
`else
    localparam int VW = 8 + 3 * DATA_W + REG_W;
`endif

    logic clk = 1'b0;
    logic reset_n, stall_i, flush_i;
    logic ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
    logic ex_branch, ex_uncond_branch, ex_zero;
    logic [DATA_W-1:0] ex_alu_result, ex_write_data, ex_branch_target;
    logic [REG_W-1:0]  ex_rd;
    logic mem_valid, mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write;
    logic mem_branch, mem_uncond_branch, mem_zero;
    logic [DATA_W-1:0] mem_alu_result, mem_write_data, mem_branch_target;
    logic [REG_W-1:0]  mem_rd;
    logic [CNT_W-1:0]  squash_count;
`ifdef EX_MEM_FLAGS_EN
    logic [3:0] ex_nzcv, mem_nzcv;
    logic [3:0] e_nzcv;
`endif

    // Expected register contents, maintained by the reference model
    logic e_valid, e_rw, e_m2r, e_mr, e_mw, e_br, e_ub, e_zero;
    logic [DATA_W-1:0] e_alu, e_wd, e_bt;
    logic [REG_W-1:0]  e_rd;
    int e_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mem_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_uncond_branch(ex_uncond_branch), .ex_zero(ex_zero),
        .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
        .ex_branch_target(ex_branch_target), .ex_rd(ex_rd),
`ifdef EX_MEM_FLAGS_EN
        .ex_nzcv(ex_nzcv), .mem_nzcv(mem_nzcv),
`endif
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_branch(mem_branch),
        .mem_uncond_branch(mem_uncond_branch), .mem_zero(mem_zero),
        .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
        .mem_branch_target(mem_branch_target), .mem_rd(mem_rd), .squash_count(squash_count)
    );

    function automatic logic [VW-1:0] act_vec();
`ifdef EX_MEM_FLAGS_EN
        return {mem_valid, mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write, mem_branch,
                mem_uncond_branch, mem_zero, mem_alu_result, mem_write_data, mem_branch_target,
                mem_rd, mem_nzcv};
`else
        return {mem_valid, mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write, mem_branch,
                mem_uncond_branch, mem_zero, mem_alu_result, mem_write_data, mem_branch_target,
                mem_rd};
`endif
    endfunction

    function automatic logic [VW-1:0] exp_vec();
`ifdef EX_MEM_FLAGS_EN
        return {e_valid, e_rw, e_m2r, e_mr, e_mw, e_br, e_ub, e_zero, e_alu, e_wd, e_bt, e_rd, e_nzcv};
`else
        return {e_valid, e_rw, e_m2r, e_mr, e_mw, e_br, e_ub, e_zero, e_alu, e_wd, e_bt, e_rd};
`endif
    endfunction

    task automatic model_clear();
        {e_valid, e_rw, e_m2r, e_mr, e_mw, e_br, e_ub, e_zero} = '0;
        e_alu = '0; e_wd = '0; e_bt = '0; e_rd = '0;
`ifdef EX_MEM_FLAGS_EN
        e_nzcv = '0;
`endif
    endtask

    // What the register should hold after the coming edge, from the current inputs
    task automatic model_edge();
        if (!reset_n) begin
            model_clear();
            e_cnt = 0;
        end else if (flush_i) begin
            model_clear();
            if (ex_valid && e_cnt < CNT_MAX) e_cnt = e_cnt + 1;
        end else if (!stall_i) begin
            e_valid = ex_valid;
            e_rw    = ex_valid && ex_reg_write && (ex_rd != 5'd31);
            e_m2r   = ex_mem_to_reg;
            e_mr    = ex_valid && ex_mem_read;
            e_mw    = ex_valid && ex_mem_write;
            e_br    = ex_valid && ex_branch;
            e_ub    = ex_valid && ex_uncond_branch;
            e_zero  = ex_zero;
            e_alu   = ex_alu_result;
            e_wd    = ex_write_data;
            e_bt    = ex_branch_target;
            e_rd    = ex_rd;
`ifdef EX_MEM_FLAGS_EN
            e_nzcv  = ex_nzcv;
`endif
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [DATA_W-1:0] d);
        {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write} = {5{v}};
        {ex_branch, ex_uncond_branch, ex_zero} = {3{v}};
        ex_alu_result = d; ex_write_data = d; ex_branch_target = d;
        ex_rd = v ? 5'd31 : 5'd0;
`ifdef EX_MEM_FLAGS_EN
        ex_nzcv = v ? 4'hF : 4'h0;
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
        set_ex(1'b1, '1);
        tick();
        tick();
        checks++;
        if (act_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", act_vec());
        end
        checks++;
        if (squash_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", squash_count);
        end
        reset_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        set_ex(1'b0, '0);
        tick();
    endtask

    task automatic test_load();
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; ex_alu_result = 64'h1234;
        ex_branch = 1'b1; ex_zero = 1'b1;
        tick();
        checks++;
        if ({mem_rd, mem_alu_result, mem_branch, mem_zero, mem_reg_write} !== {5'd5, 64'h1234, 3'b111}) begin
            errors++;
            $display("FAIL load_fields: got rd=%0d alu=%h br=%b z=%b rw=%b want rd=5 alu=1234 br=1 z=1 rw=1",
                     mem_rd, mem_alu_result, mem_branch, mem_zero, mem_reg_write);
        end
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL load_model: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1; ex_alu_result = 64'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_alu_result !== 64'h1234) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h want 1234", i, mem_alu_result);
            end
        end
        stall_i = 1'b0;
        tick();
        checks++;
        if (mem_alu_result !== 64'hFFFF) begin
            errors++;
            $display("FAIL stall_release: got %h want ffff", mem_alu_result);
        end
    endtask

    task automatic test_flush();
        stall_i = 1'b1; flush_i = 1'b1; ex_valid = 1'b1;
        tick();
        checks++;
        if (act_vec() !== '0) begin
            errors++;
            $display("FAIL flush_bubble: got %h want 0", act_vec());
        end
        checks++;
        if (squash_count !== 2'd1) begin
            errors++;
            $display("FAIL flush_count: got %0d want 1", squash_count);
        end
        stall_i = 1'b0; ex_valid = 1'b0;
        tick();
        checks++;
        if (squash_count !== 2'd1) begin
            errors++;
            $display("FAIL flush_invalid_count: got %0d want 1", squash_count);
        end
        flush_i = 1'b0;
    endtask

    task automatic test_gating();
        ex_valid = 1'b0; ex_mem_write = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        ex_rd = 5'd7; ex_alu_result = 64'hABCD;
        tick();
        checks++;
        if ({mem_mem_write, mem_mem_read, mem_reg_write, mem_alu_result} !== {3'b000, 64'hABCD}) begin
            errors++;
            $display("FAIL gate_invalid: got mw=%b mr=%b rw=%b alu=%h want 0 0 0 abcd",
                     mem_mem_write, mem_mem_read, mem_reg_write, mem_alu_result);
        end
        ex_valid = 1'b1; ex_rd = 5'd31;
        tick();
        checks++;
        if ({mem_reg_write, mem_rd, mem_mem_write} !== {1'b0, 5'd31, 1'b1}) begin
            errors++;
            $display("FAIL gate_xzr: got rw=%b rd=%0d mw=%b want rw=0 rd=31 mw=1",
                     mem_reg_write, mem_rd, mem_mem_write);
        end
    endtask

    task automatic test_saturation();
        int want [5] = '{1, 2, 3, 3, 3};
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; flush_i = 1'b1; ex_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (squash_count !== want[i][CNT_W-1:0]) begin
                errors++;
                $display("FAIL saturate[%0d]: got %0d want %0d", i, squash_count, want[i]);
            end
        end
        flush_i = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 19) != 0);
            flush_i = ($urandom_range(0, 4) == 0);
            stall_i = ($urandom_range(0, 3) == 0);
            {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read} = 4'($urandom);
            {ex_mem_write, ex_branch, ex_uncond_branch, ex_zero} = 4'($urandom);
            ex_alu_result    = {$urandom, $urandom};
            ex_write_data    = {$urandom, $urandom};
            ex_branch_target = {$urandom, $urandom};
            ex_rd = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
`ifdef EX_MEM_FLAGS_EN
            ex_nzcv = 4'($urandom);
`endif
            tick();
            checks++;
            if (act_vec() !== exp_vec() || int'(squash_count) != e_cnt) begin
                errors++;
                $display("FAIL random[%0d]: got %h cnt=%0d want %h cnt=%0d",
                         i, act_vec(), squash_count, exp_vec(), e_cnt);
            end
        end
    endtask

    initial begin
        e_cnt = 0;
        model_clear();
        test_reset();
        test_load();
        test_stall();
        test_flush();
        test_gating();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the segmented ARMv8 core.
- Captures the execute-stage result, zero flag and branch/memory/writeback controls, and presents them to the MEM stage.
- Its mem_branch and mem_zero outputs drive the branch-decision AND gate, which forms the PC-source select.
- Supports stall (hold), flush (bubble insertion) and a saturating squash counter for debug.

Parameters:
- DATA_W, 64, width of ALU result, store data and branch target.
- REG_W, 5, width of destination register index.
- CNT_W, 8, width of squash counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous reset, active low.
- stall_i  in  1  hold current contents.
- flush_i  in  1  load a bubble instead of the EX instruction.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_reg_write  in  1  writeback enable.
- ex_mem_to_reg  in  1  writeback source select (1 = memory).
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_branch  in  1  conditional branch (CBZ).
- ex_uncond_branch  in  1  unconditional branch (B).
- ex_zero  in  1  ALU zero flag.
- ex_alu_result  in  DATA_W  ALU result / address.
- ex_write_data  in  DATA_W  store data.
- ex_branch_target  in  DATA_W  computed PC + offset.
- ex_rd  in  REG_W  destination register.
- mem_valid, mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write, mem_branch, mem_uncond_branch, mem_zero  out  1 each  registered counterparts of the ex_* inputs.
- mem_alu_result, mem_write_data, mem_branch_target  out  DATA_W each  registered counterparts.
- mem_rd  out  REG_W  registered counterpart.
- squash_count  out  CNT_W  number of valid instructions discarded by flush.

Behaviour:
- All state updates on posedge clk only.
- Priority at each edge: reset > flush > stall > load.
- Reset (reset_n=0 at edge):
  - every output, including squash_count, goes to 0.
  - reset mid-stall or mid-flush is still a full clear.
- Flush (flush_i=1):
  - all mem_* outputs load 0 (clean bubble, data fields included).
  - stall_i is ignored that cycle.
- Stall (stall_i=1, flush_i=0): all mem_* outputs hold their previous values.
- Load (stall_i=0, flush_i=0):
  - all mem_* outputs take their ex_* inputs with 1-cycle latency.
  - control gating: if ex_valid=0, mem_reg_write, mem_mem_read, mem_mem_write, mem_branch and mem_uncond_branch load 0; data fields still load.
  - XZR rule: if ex_rd=31, mem_reg_write loads 0 regardless of ex_reg_write.
- mem_zero is a plain copy of ex_zero. Branch qualification is done downstream, never here.
- squash_count:
  - increments by 1 on an edge with flush_i=1, ex_valid=1 and reset_n=1.
  - saturates at 2^CNT_W-1; no wrap.
  - unaffected by stall.
- No combinational path from any input to any output.

Optional Feature:
- Macro: EX_MEM_FLAGS_EN.
- When defined:
  - adds input ex_nzcv[3:0] and output mem_nzcv[3:0].
  - mem_nzcv follows the same reset/flush/stall/load rules as data fields (reset 0, flush 0, hold on stall, load otherwise) for B.cond support.
- When undefined: those ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with all ex_* inputs =1/all-ones -> every output 0, squash_count=0.
- Load: ex_valid=1, ex_reg_write=1, ex_rd=5, ex_alu_result=0x1234, ex_branch=1, ex_zero=1 -> next edge mem_rd=5, mem_alu_result=0x1234, mem_branch=1, mem_zero=1, mem_reg_write=1.
- Stall then change inputs: stall_i=1 for 3 cycles while ex_alu_result=0xFFFF -> mem_alu_result stays 0x1234; release stall -> next edge 0xFFFF.
- Flush with simultaneous stall: stall_i=1, flush_i=1, ex_valid=1 -> next edge all mem_* =0, squash_count increments 0->1; flush with ex_valid=0 -> count unchanged.
- Gating: ex_valid=0 with ex_mem_write=1 -> mem_mem_write=0; ex_rd=31 with ex_reg_write=1 -> mem_reg_write=0.
- Saturation: CNT_W=2, 5 consecutive flushes with ex_valid=1 -> squash_count sequence 1,2,3,3,3.
